// File: rtl/mips32_loader_pkg.sv
// Shared types and constants for the MIPS32 boot-time program loader.
package mips32_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    START,
    ERR
  } state_t;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned HDR_LEN           = 4;

endpackage

// File: rtl/mips32_word_asm.sv
// Big-endian byte-to-word shifter with a running XOR over every accepted byte.
module mips32_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_stb,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= '0;
      shreg    <= '0;
      csum     <= '0;
    end else if (byte_stb) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= {shreg[15:0], byte_in};
      csum     <= csum ^ byte_in;
    end
  end

  // The 4th byte completes the word combinationally; the consumer registers it.
  assign word_valid = byte_stb && (byte_cnt == 2'd3);
  assign word       = {shreg, byte_in};

endmodule

// File: rtl/mips32_prog_loader.sv
// Framed byte-stream loader: writes a checksummed image into core memory,
// then releases the halted core with an entry PC.
module mips32_prog_loader
  import mips32_loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_halt,
  output logic              core_start,
  output logic [31:0]       core_pc,
  output logic              busy,
  output logic              err
);

  localparam logic [16:0] MEM_DEPTH = 17'd1 << ADDR_W;

  state_t      state, state_nxt;
  logic        accept;
  logic        sync_seen;
  logic        hdr_last;
  logic [23:0] hdr_q;
  logic [1:0]  hdr_cnt;
  logic [31:0] hdr_word;
  logic [16:0] hdr_span;
  logic [15:0] load_addr;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic        released;
  logic        word_valid;
  logic [31:0] word;
  logic [7:0]  csum;

  assign in_ready  = !rst && (state != START) && (state != ERR);
  assign accept    = in_valid && in_ready;
  assign sync_seen = (state == IDLE) && accept && (in_data == SYNC_BYTE);
  assign hdr_last  = (state == HDR) && accept && (hdr_cnt == 2'(HDR_LEN - 1));
  assign hdr_word  = {hdr_q, in_data};
  assign hdr_span  = {1'b0, hdr_word[31:16]} + {1'b0, hdr_word[15:0]};

  mips32_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_stb   (accept && (state == DATA)),
    .clear      ((state == IDLE) || (state == HDR)),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word),
    .csum       (csum)
  );

  // NOTE: next-state is assigned a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (sync_seen) state_nxt = HDR;
      HDR: begin
        if (hdr_last) begin
          if (hdr_span > MEM_DEPTH)          state_nxt = ERR;
          else if (hdr_word[15:0] == 16'd0)  state_nxt = CSUM;
          else                               state_nxt = DATA;
        end
      end
      DATA:  if (word_valid && (word_idx == count - 16'd1)) state_nxt = CSUM;
      CSUM:  if (accept) state_nxt = (in_data == csum) ? START : ERR;
      START: state_nxt = IDLE;
      ERR:   state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hdr_q     <= '0;
      hdr_cnt   <= '0;
      load_addr <= '0;
      count     <= '0;
      word_idx  <= '0;
      released  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= word_valid;
      if (word_valid) begin
        mem_addr  <= load_addr[ADDR_W-1:0] + word_idx[ADDR_W-1:0];
        mem_wdata <= word;
        word_idx  <= word_idx + 16'd1;
      end
      if (sync_seen) begin
        released <= 1'b0;
        hdr_cnt  <= '0;
        word_idx <= '0;
      end
      if ((state == HDR) && accept) begin
        hdr_q   <= hdr_word[23:0];
        hdr_cnt <= hdr_cnt + 2'd1;
      end
      if (hdr_last) begin
        load_addr <= hdr_word[31:16];
        count     <= hdr_word[15:0];
      end
      if (state == START) released <= 1'b1;
    end
  end

  // The core runs only during the start pulse and after a verified load.
  assign core_start = (state == START);
  assign core_pc    = core_start ? {16'd0, load_addr} : 32'd0;
  assign core_halt  = !(core_start || released);
  assign busy       = (state == HDR) || (state == DATA) || (state == CSUM);
  assign err        = (state == ERR);

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for the program loader: frames, gaps, errors, resets.
module tb_mips32_prog_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_halt;
  logic              core_start;
  logic [31:0]       core_pc;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  mips32_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_halt  (core_halt),
    .core_start (core_start),
    .core_pc    (core_pc),
    .busy       (busy),
    .err        (err)
  );

  int          checks = 0;
  int          passes = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          start_cnt = 0;
  int          overlap = 0;
  logic [31:0] start_pc;
  logic        start_halt;
  logic [31:0] img [0:15];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(32'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
    if (core_start) begin
      start_cnt++;
      start_pc   = core_pc;
      start_halt = core_halt;
    end
    if (mem_we && core_start) overlap++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    start_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100 && !done; t++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end
  endtask

  // stop_after: -1 full frame, -2 header only, n>=0 stop after n payload bytes
  task automatic send_frame(input logic [15:0] addr, input logic [15:0] cnt,
                            input logic [7:0] flip, input int max_gap, input int stop_after);
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    send_byte(8'hA5, $urandom_range(0, max_gap));
    send_byte(addr[15:8], $urandom_range(0, max_gap));
    send_byte(addr[7:0], $urandom_range(0, max_gap));
    send_byte(cnt[15:8], $urandom_range(0, max_gap));
    send_byte(cnt[7:0], $urandom_range(0, max_gap));
    if (stop_after == -2) return;
    for (int i = 0; i < int'(cnt); i++) begin
      w = img[i];
      for (int j = 3; j >= 0; j--) begin
        if (stop_after >= 0 && (i * 4 + (3 - j)) >= stop_after) return;
        send_byte(w[8*j +: 8], $urandom_range(0, max_gap));
        cs ^= w[8*j +: 8];
      end
    end
    send_byte(cs ^ flip, $urandom_range(0, max_gap));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_halt", 32'(core_halt), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_start", 32'(core_start), 32'd0);
    check("rst_pc", core_pc, 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_wdata", mem_wdata, 32'd0);
    do_reset();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Factorial image at address 0
    img[0] = 32'h280a00c8; img[1] = 32'h28020001; img[2]  = 32'h0e94a000;
    img[3] = 32'h21430000; img[4] = 32'h0e94a000; img[5]  = 32'h14431000;
    img[6] = 32'h2c630001; img[7] = 32'h0e94a000; img[8]  = 32'h3460fffc;
    img[9] = 32'h2542fffe; img[10] = 32'hfc000000;
    clear_log();
    send_frame(16'h0000, 16'd11, 8'h00, 0, -1);
    repeat (3) @(negedge clk);
    check("fact_nwr", 32'(wr_addr.size()), 32'd11);
    for (int i = 0; i < 11 && i < wr_addr.size(); i++) begin
      check($sformatf("fact_addr%0d", i), wr_addr[i], 32'(i));
      check($sformatf("fact_data%0d", i), wr_data[i], img[i]);
    end
    check("fact_starts", 32'(start_cnt), 32'd1);
    check("fact_pc", start_pc, 32'd0);
    check("fact_halt_at_start", 32'(start_halt), 32'd0);
    check("fact_halt_after", 32'(core_halt), 32'd0);
    check("fact_busy_after", 32'(busy), 32'd0);

    // Garbage prefix, then 2 words at 0x0C8 with random gaps
    img[0] = 32'hDEADBEEF; img[1] = 32'h01234567;
    clear_log();
    send_byte(8'h00, 2);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 3);
    @(negedge clk);
    check("garbage_no_halt", 32'(core_halt), 32'd0);
    check("garbage_no_busy", 32'(busy), 32'd0);
    send_frame(16'h00C8, 16'd2, 8'h00, 3, -1);
    repeat (3) @(negedge clk);
    check("gap_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("gap_addr0", wr_addr[0], 32'd200);
      check("gap_data0", wr_data[0], 32'hDEADBEEF);
      check("gap_addr1", wr_addr[1], 32'd201);
      check("gap_data1", wr_data[1], 32'h01234567);
    end
    check("gap_starts", 32'(start_cnt), 32'd1);
    check("gap_pc", start_pc, 32'd200);

    // A new sync re-halts the core on the next cycle
    send_byte(8'hA5, 0);
    check("resync_halt", 32'(core_halt), 32'd1);
    check("resync_busy", 32'(busy), 32'd1);
    do_reset();

    // Checksum mismatch
    clear_log();
    send_frame(16'h00C8, 16'd2, 8'h01, 1, -1);
    repeat (5) @(negedge clk);
    check("bad_nwr", 32'(wr_addr.size()), 32'd2);
    check("bad_starts", 32'(start_cnt), 32'd0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_halt", 32'(core_halt), 32'd1);
    check("bad_in_ready", 32'(in_ready), 32'd0);
    check("bad_busy", 32'(busy), 32'd0);
    do_reset();
    check("bad_err_cleared", 32'(err), 32'd0);

    // Overflow: 0x3FF + 2 > 1024
    clear_log();
    send_frame(16'h03FF, 16'd2, 8'h00, 0, -2);
    @(negedge clk);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("ovf_nwr", 32'(wr_addr.size()), 32'd0);
    do_reset();

    // Exact fit: 0x3FE + 2 == 1024 is allowed
    clear_log();
    send_frame(16'h03FE, 16'd2, 8'h00, 0, -1);
    repeat (3) @(negedge clk);
    check("fit_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("fit_addr0", wr_addr[0], 32'd1022);
      check("fit_addr1", wr_addr[1], 32'd1023);
    end
    check("fit_pc", start_pc, 32'h3FE);
    check("fit_err", 32'(err), 32'd0);

    // COUNT = 0
    clear_log();
    send_frame(16'h0005, 16'd0, 8'h00, 0, -1);
    repeat (3) @(negedge clk);
    check("zero_nwr", 32'(wr_addr.size()), 32'd0);
    check("zero_starts", 32'(start_cnt), 32'd1);
    check("zero_pc", start_pc, 32'd5);

    // Reset after 6 payload bytes
    clear_log();
    send_frame(16'h0010, 16'd2, 8'h00, 0, 6);
    @(negedge clk);
    do_reset();
    repeat (2) @(negedge clk);
    check("mid_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("mid_addr0", wr_addr[0], 32'd16);
      check("mid_data0", wr_data[0], 32'hDEADBEEF);
    end
    check("mid_starts", 32'(start_cnt), 32'd0);
    clear_log();
    send_frame(16'h0010, 16'd2, 8'h00, 2, -1);
    repeat (3) @(negedge clk);
    check("reload_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("reload_addr1", wr_addr[1], 32'd17);
      check("reload_data1", wr_data[1], 32'h01234567);
    end
    check("reload_pc", start_pc, 32'd16);
    check("we_start_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
